// File: rtl/coder_pkg.sv
// Shared constants and helpers for the 16-to-4 request encoder family.
package coder_pkg;

  localparam int REQ_W = 16;
  localparam int IDX_W = 4;

  // Rotate a request vector right so that bit 'sh' lands at position 0.
  function automatic logic [REQ_W-1:0] rotr16(input logic [REQ_W-1:0] v,
                                              input logic [IDX_W-1:0] sh);
    logic [2*REQ_W-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[REQ_W-1:0];
  endfunction

endpackage

// File: rtl/encoder_16_4_pend_if.sv
// Request/result bundle between the event sources/consumer and the encoder.
interface encoder_16_4_pend_if;
  import coder_pkg::*;

  logic [REQ_W-1:0] inp;
  logic [REQ_W-1:0] msk;
  logic             clr;
  logic             rdy;
  logic [IDX_W-1:0] res;
  logic             vld;
  logic [REQ_W-1:0] pnd;
  logic             ovr;

  modport master (output inp, msk, clr, rdy, input res, vld, pnd, ovr);
  modport slave  (input inp, msk, clr, rdy, output res, vld, pnd, ovr);
endinterface

// File: rtl/prio_enc_16_4.sv
// Combinational fixed-priority encoder: lowest set bit wins.
module prio_enc_16_4
  import coder_pkg::*;
(
  input  logic [REQ_W-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    found = |req;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/encoder_16_4_pend.sv
// Latching 16-to-4 request encoder: rising edges become sticky pending
// bits, one unmasked pending request is claimed into a single-entry
// valid/ready output register, by fixed or round-robin priority.
module encoder_16_4_pend
  import coder_pkg::*;
#(
  parameter bit PRIO_RR = 1'b0
) (
  input  logic                clk,
  input  logic                rstn,
  encoder_16_4_pend_if.slave  bus
);

  logic [REQ_W-1:0] prev_p0;
  logic [REQ_W-1:0] pnd_p0;
  logic             ovr_p0;
  logic [IDX_W-1:0] last_p0;
  logic [IDX_W-1:0] res_p1;
  logic             vld_p1;

  logic [REQ_W-1:0] rise;
  logic [REQ_W-1:0] cand;
  logic [REQ_W-1:0] cand_rot;
  logic [REQ_W-1:0] win_oh;
  logic [REQ_W-1:0] pnd_nxt;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] enc_idx;
  logic [IDX_W-1:0] win;
  logic             found;
  logic             free;
  logic             claim;
  logic             ovr_hit;

  // ---- stage 0: edge detect, pending bits, winner selection ----
  assign rise     = bus.inp & ~prev_p0;
  assign cand     = pnd_p0 & ~bus.msk;
  // Fixed priority is round-robin with the search origin pinned at 0.
  assign start    = PRIO_RR ? last_p0 + 4'd1 : '0;
  assign cand_rot = rotr16(cand, start);

  prio_enc_16_4 u_enc (
    .req   (cand_rot),
    .idx   (enc_idx),
    .found (found)
  );

  assign win     = enc_idx + start;
  assign free    = !vld_p1 || bus.rdy;
  assign claim   = free && found;
  assign win_oh  = claim ? (REQ_W'(1) << win) : '0;
  // A rise on the bit being claimed re-arms it rather than counting as overrun.
  assign pnd_nxt = (pnd_p0 & ~win_oh) | rise;
  assign ovr_hit = |(rise & pnd_p0 & ~win_oh);

  // Edge history, pending/overrun state and round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_p0 <= '0;
      pnd_p0  <= '0;
      ovr_p0  <= 1'b0;
      last_p0 <= 4'd15;
    end else begin
      prev_p0 <= bus.inp;
      if (bus.clr) begin
        pnd_p0 <= '0;
        ovr_p0 <= 1'b0;
      end else begin
        pnd_p0 <= pnd_nxt;
        if (ovr_hit) ovr_p0 <= 1'b1;
        if (claim && PRIO_RR) last_p0 <= win;
      end
    end
  end

  // ---- stage 1: single-entry output register ----
  // Output register: load on claim, empty when free with nothing to claim.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (bus.clr) begin
      vld_p1 <= 1'b0;
    end else if (free) begin
      vld_p1 <= found;
      if (found) res_p1 <= win;
    end
  end

  assign bus.res = res_p1;
  assign bus.vld = vld_p1;
  assign bus.pnd = pnd_p0;
  assign bus.ovr = ovr_p0;

endmodule

// File: tb/tb_encoder_16_4_pend.sv
// Bench for encoder_16_4_pend: fixed-priority and round-robin instances
// share stimulus; each is compared every cycle against a behavioural
// model, plus directed scenario checks.
module tb_encoder_16_4_pend;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] inp  = '0;
  logic [15:0] msk  = '0;
  logic        clr  = 1'b0;
  logic        rdy  = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  encoder_16_4_pend_if if0 ();
  encoder_16_4_pend_if if1 ();

  assign if0.inp = inp;
  assign if0.msk = msk;
  assign if0.clr = clr;
  assign if0.rdy = rdy;
  assign if1.inp = inp;
  assign if1.msk = msk;
  assign if1.clr = clr;
  assign if1.rdy = rdy;

  encoder_16_4_pend #(.PRIO_RR(1'b0)) u_fix (.clk(clk), .rstn(rstn), .bus(if0));
  encoder_16_4_pend #(.PRIO_RR(1'b1)) u_rr  (.clk(clk), .rstn(rstn), .bus(if1));

  always #5 clk = ~clk;

  // Behavioural model, index 0 = fixed priority, 1 = round-robin.
  logic [15:0] m_pnd  [2];
  logic [15:0] m_prev [2];
  int          m_res  [2];
  int          m_last [2];
  bit          m_vld  [2];
  bit          m_ovr  [2];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pnd[m]  = '0;
      m_prev[m] = '0;
      m_res[m]  = 0;
      m_last[m] = 15;
      m_vld[m]  = 1'b0;
      m_ovr[m]  = 1'b0;
    end
  endtask

  task automatic model_step(input int m);
    logic [15:0] rise;
    logic [15:0] cand;
    bit          free;
    bit          found;
    int          win;
    rise      = inp & ~m_prev[m];
    m_prev[m] = inp;
    if (clr) begin
      m_pnd[m] = '0;
      m_ovr[m] = 1'b0;
      m_vld[m] = 1'b0;
    end else begin
      free  = !m_vld[m] || rdy;
      found = 1'b0;
      win   = 0;
      cand  = m_pnd[m] & ~msk;
      if (free) begin
        for (int k = 0; k < 16; k++) begin
          int idx;
          idx = (m == 0) ? k : (m_last[m] + 1 + k) % 16;
          if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        if (rise[i] && m_pnd[m][i] && !(found && i == win)) m_ovr[m] = 1'b1;
      end
      m_pnd[m] = m_pnd[m] | rise;
      if (found) begin
        m_pnd[m][win] = rise[win];
        m_res[m]      = win;
        m_vld[m]      = 1'b1;
        if (m == 1) m_last[m] = win;
      end else if (free) begin
        m_vld[m] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rstn) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge rstn) model_reset();

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    chk("fix.res", 16'(if0.res), 16'(m_res[0]));
    chk("fix.vld", 16'(if0.vld), 16'(m_vld[0]));
    chk("fix.pnd", if0.pnd, m_pnd[0]);
    chk("fix.ovr", 16'(if0.ovr), 16'(m_ovr[0]));
    chk("rr.res",  16'(if1.res), 16'(m_res[1]));
    chk("rr.vld",  16'(if1.vld), 16'(m_vld[1]));
    chk("rr.pnd",  if1.pnd, m_pnd[1]);
    chk("rr.ovr",  16'(if1.ovr), 16'(m_ovr[1]));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    model_reset();
    cyc(3);
    chk("rst.res", 16'(if0.res), 16'h0);
    chk("rst.vld", 16'(if0.vld), 16'h0);
    chk("rst.pnd", if0.pnd, 16'h0);
    chk("rst.ovr", 16'(if1.ovr), 16'h0);
    rstn = 1'b1;

    // Fixed order
    rdy = 1'b1;
    inp = 16'h0024;
    cyc(1);
    chk("fix.k.pnd", if0.pnd, 16'h0024);
    chk("fix.k.vld", 16'(if0.vld), 16'h0);
    cyc(1);
    chk("fix.k1.res", 16'(if0.res), 16'd2);
    chk("fix.k1.vld", 16'(if0.vld), 16'h1);
    chk("fix.k1.pnd", if0.pnd, 16'h0020);
    cyc(1);
    chk("fix.k2.res", 16'(if0.res), 16'd5);
    chk("fix.k2.pnd", if0.pnd, 16'h0000);
    cyc(1);
    chk("fix.k3.vld", 16'(if0.vld), 16'h0);
    inp = 16'h0000;
    cyc(1);

    // Backpressure
    rdy = 1'b0;
    inp = 16'h0004;
    cyc(2);
    chk("bp.res", 16'(if0.res), 16'd2);
    chk("bp.vld", 16'(if0.vld), 16'h1);
    inp = 16'h0204;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("bp.hold.res", 16'(if0.res), 16'd2);
      chk("bp.hold.vld", 16'(if0.vld), 16'h1);
      chk("bp.hold.pnd", if0.pnd, 16'h0200);
    end
    rdy = 1'b1;
    cyc(1);
    chk("bp.rel.res", 16'(if0.res), 16'd9);
    chk("bp.rel.vld", 16'(if0.vld), 16'h1);
    inp = 16'h0000;
    cyc(1);
    chk("bp.empty.vld", 16'(if0.vld), 16'h0);

    // Mask
    msk = 16'h0004;
    inp = 16'h0004;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      chk("msk.pnd", if0.pnd, 16'h0004);
      chk("msk.vld", 16'(if0.vld), 16'h0);
    end
    msk = 16'h0000;
    cyc(1);
    chk("msk.rel.res", 16'(if0.res), 16'd2);
    chk("msk.rel.vld", 16'(if0.vld), 16'h1);
    inp = 16'h0000;
    cyc(1);

    // Round-robin
    inp = 16'h0003;
    cyc(2);
    chk("rr.a0", 16'(if1.res), 16'd0);
    cyc(1);
    chk("rr.a1", 16'(if1.res), 16'd1);
    inp = 16'h0000;
    cyc(1);
    inp = 16'h0009;
    cyc(2);
    chk("rr.b0", 16'(if1.res), 16'd3);
    chk("fix.b0", 16'(if0.res), 16'd0);
    cyc(1);
    chk("rr.b1", 16'(if1.res), 16'd0);
    chk("fix.b1", 16'(if0.res), 16'd3);
    inp = 16'h0000;
    cyc(1);

    // Overrun and clear
    rdy = 1'b0;
    inp = 16'h0001;
    cyc(2);
    chk("ovr.occ.vld", 16'(if0.vld), 16'h1);
    inp = 16'h0009;
    cyc(1);
    inp = 16'h0001;
    cyc(1);
    inp = 16'h0009;
    cyc(1);
    chk("ovr.pnd", if0.pnd, 16'h0008);
    chk("ovr.flag", 16'(if0.ovr), 16'h1);
    clr = 1'b1;
    inp = 16'h0019;
    cyc(1);
    chk("clr.pnd", if0.pnd, 16'h0000);
    chk("clr.ovr", 16'(if0.ovr), 16'h0);
    chk("clr.vld", 16'(if0.vld), 16'h0);
    clr = 1'b0;
    cyc(1);
    chk("clr.bit4", if0.pnd, 16'h0000);

    // Asynchronous reset in the middle of a delivery
    inp = 16'h0000;
    cyc(1);
    inp = 16'h0002;
    cyc(2);
    inp = 16'h0102;
    cyc(1);
    chk("pre.vld", 16'(if0.vld), 16'h1);
    chk("pre.pnd", if0.pnd, 16'h0100);
    #3 rstn = 1'b0;
    #1;
    chk("arst.res", 16'(if0.res), 16'h0);
    chk("arst.vld", 16'(if0.vld), 16'h0);
    chk("arst.pnd", if0.pnd, 16'h0);
    chk("arst.ovr", 16'(if0.ovr), 16'h0);
    chk("arst.rr.vld", 16'(if1.vld), 16'h0);
    chk("arst.rr.pnd", if1.pnd, 16'h0);
    inp = 16'h0000;
    cyc(1);
    rstn = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      inp = 16'($urandom) & 16'($urandom);
      msk = 16'($urandom) & 16'($urandom) & 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
    end
    clr = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
